// File: rtl/sat_narrow_skid_pkg.sv
// ==== sat_narrow_skid_pkg : skid state encodings and width check ====
// ==== rev 1.0                                                     ====
`default_nettype none

package sat_narrow_skid_pkg;

  localparam logic [1:0] SKID_EMPTY = 2'd0;
  localparam logic [1:0] SKID_ONE   = 2'd1;
  localparam logic [1:0] SKID_FULL  = 2'd2;

  // True when the narrowing geometry is legal: 0 <= nbits < din, 1 <= dout <= din-nbits.
  function automatic bit sat_narrow_f(input int din, input int nbits, input int dout);
    return (nbits >= 0) && (nbits < din) && (dout >= 1) && (dout <= din - nbits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_narrow_skid_sat_narrow.sv
// ==== sat_narrow : combinational saturate of W-bit word to DOUT bits ====
// ==== rev 1.0                                                        ====
`default_nettype none

module sat_narrow #(
  parameter int W      = 12,
  parameter int DOUT   = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic [W-1:0]    w,
  output logic [DOUT-1:0] dout,
  output logic            sat
);

  generate
    if (SIGNED) begin : g_signed
      localparam logic [DOUT-1:0] SMIN = DOUT'(1) << (DOUT - 1);
      logic [W-DOUT:0] hi;
      assign hi = w[W-1:DOUT-1];
      always_comb begin
        sat  = !((&hi) || !(|hi));
        dout = sat ? (w[W-1] ? SMIN : ~SMIN) : w[DOUT-1:0];
      end
    end else begin : g_unsigned
      if (W == DOUT) begin : g_uns_full
        assign sat  = 1'b0;
        assign dout = w;
      end else begin : g_uns_wide
        always_comb begin
          sat  = |w[W-1:DOUT];
          dout = sat ? {DOUT{1'b1}} : w[DOUT-1:0];
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/sat_narrow_skid.sv
// ==== sat_narrow_skid : drop LSBs, saturate, register behind 2-entry skid ====
// ==== rev 1.0                                                            ====
`default_nettype none

module sat_narrow_skid
  import sat_narrow_skid_pkg::*;
#(
  parameter int DIN    = 16,
  parameter int NBITS  = 4,
  parameter int DOUT   = 8,
  parameter bit SIGNED = 1'b1,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [DIN-1:0]  din_data,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [DOUT-1:0] dout_data,
  output logic            dout_sat,
  input  logic            sat_clr,
  output logic [CNTW-1:0] sat_cnt
);

  localparam int W = DIN - NBITS;

  generate
    if (!sat_narrow_f(DIN, NBITS, DOUT)) begin : g_bad_width
      $error("sat_narrow_skid: illegal DIN/NBITS/DOUT combination");
    end
    if (NBITS > 0) begin : g_lsbs
      logic unused_lsbs;
      assign unused_lsbs = ^din_data[NBITS-1:0];
    end
  endgenerate

  logic [1:0]      state_q, state_d;
  logic [DOUT-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic            main_sat_q, main_sat_d, skid_sat_q, skid_sat_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [DOUT-1:0] nar_data;
  logic            nar_sat;
  logic            accept, drain;

  sat_narrow #(.W(W), .DOUT(DOUT), .SIGNED(SIGNED)) u_sat_narrow (
    .w    (din_data[DIN-1:NBITS]),
    .dout (nar_data),
    .sat  (nar_sat)
  );

  assign din_ready  = (state_q != SKID_FULL);
  assign dout_valid = (state_q != SKID_EMPTY);
  assign dout_data  = main_data_q;
  assign dout_sat   = main_sat_q;
  assign sat_cnt    = cnt_q;
  assign accept     = din_valid && din_ready;
  assign drain      = dout_valid && dout_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sat_d  = main_sat_q;
    skid_data_d = skid_data_q;
    skid_sat_d  = skid_sat_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          main_data_d = nar_data;
          main_sat_d  = nar_sat;
          state_d     = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          main_data_d = nar_data;
          main_sat_d  = nar_sat;
        end else if (accept) begin
          skid_data_d = nar_data;
          skid_sat_d  = nar_sat;
          state_d     = SKID_FULL;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (drain) begin
          main_data_d = skid_data_q;
          main_sat_d  = skid_sat_q;
          state_d     = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Counted at acceptance; clear wins over a same-cycle increment, and the count sticks at max.
  always_comb begin
    cnt_d = cnt_q;
    if (sat_clr) begin
      cnt_d = '0;
    end else if (accept && nar_sat && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SKID_EMPTY;
      main_data_q <= '0;
      main_sat_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sat_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sat_q  <= main_sat_d;
      skid_data_q <= skid_data_d;
      skid_sat_q  <= skid_sat_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

`default_nettype wire
